// File: rtl/or_n_irq_aggregator.sv
// or_n_irq_aggregator
// Collects WIDTH request/interrupt lines into one CPU interrupt output.
// Each line is synchronised into clk, then handled in one of two modes:
//   level channel : pending follows the synchronised line
//   edge channel  : a rising edge sets a sticky pending bit that is cleared
//                   by software through clr_stb/clr_bits
// The masked pending bits are ORed together. The result drives a small FSM
// that holds out high for at least STRETCH cycles, so a slow poll still sees it.
//
// Handshake / timing contract:
//   in_req may be asynchronous to clk. Pulses shorter than one clk period
//   may be lost. mask, clr_stb and clr_bits are synchronous to clk.
//   clr_stb is a single-cycle strobe, and clr_bits is looked at only while
//   clr_stb is high. A rising edge and a clear on the same bit in the same
//   cycle leave that bit set. Both pending and out are registered.
//   A change on in_req reaches out after SYNC_STAGES+2 clock edges.
module or_n_irq_aggregator #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] EDGE_MASK   = '0,
    parameter int               STRETCH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_req,
    input  logic [WIDTH-1:0] mask,
    input  logic             clr_stb,
    input  logic [WIDTH-1:0] clr_bits,
    output logic [WIDTH-1:0] pending,
    output logic             out
);

    // The stretch counter is ceil(log2(STRETCH)) bits wide, with a minimum of one bit.
    localparam int CNT_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             any;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser chain: stage 0 samples the raw lines, and the last stage is s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_req;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~h;

    // Edge history. It resets to 0, so a line that is already high when reset
    // is released counts as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
        end else begin
            h <= s;
        end
    end

    // Next pending value for each bit. In an edge channel, a set beats a clear.
    // A level channel ignores clears.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (EDGE_MASK[i]) begin
                if (rise[i]) begin
                    pending_d[i] = 1'b1;
                end else if (clr_stb && clr_bits[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = s[i];
            end
        end
    end

    // Pending flag register, shown to software unmasked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
    assign any     = |(pending_q & mask);

    // Registers for the output FSM state and the stretch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next state for the stretch FSM. The counter is loaded once on entry to
    // ACTIVE and then counts down to zero, where it stays. The FSM returns to
    // IDLE only when the count has run out and nothing is requesting.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (any) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACTIVE: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (!any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // out is a decode of the state register, so it comes straight from a flop.
    assign out = (state == ACTIVE);

endmodule

// File: tb/tb_or_n_irq_aggregator.sv
// Directed testbench for or_n_irq_aggregator.
// DUT setup: WIDTH=8, SYNC_STAGES=2, STRETCH=4.
// Channels 3 and 5 are edge channels. All other channels are level channels.
module tb_or_n_irq_aggregator;

    logic       clk;
    logic       reset;
    logic [7:0] in_req;
    logic [7:0] mask;
    logic       clr_stb;
    logic [7:0] clr_bits;
    logic [7:0] pending;
    logic       out;

    int total;
    int bad;

    or_n_irq_aggregator #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .EDGE_MASK  (8'h28),
        .STRETCH    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_req  (in_req),
        .mask    (mask),
        .clr_stb (clr_stb),
        .clr_bits(clr_bits),
        .pending (pending),
        .out     (out)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge. Sampling and driving both happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bring the DUT to a quiet state: no requests, no pending bits, out low.
    task automatic settle();
        in_req   = 8'h00;
        mask     = 8'h00;
        clr_stb  = 1'b0;
        clr_bits = 8'h00;
        repeat (6) step();
        clr_stb  = 1'b1;
        clr_bits = 8'hFF;
        step();
        clr_stb  = 1'b0;
        clr_bits = 8'h00;
        repeat (6) step();
    endtask

    // Hold reset with all inputs high, then release and track the latency.
    task automatic test_reset();
        in_req   = 8'hFF;
        mask     = 8'hFF;
        clr_stb  = 1'b0;
        clr_bits = 8'h00;
        reset    = 1'b1;
        repeat (3) step();
        total++;
        if (pending !== 8'h00) begin
            $display("FAIL reset_pending: got %h want 00", pending);
            bad++;
        end
        total++;
        if (out !== 1'b0) begin
            $display("FAIL reset_out: got %b want 0", out);
            bad++;
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (out !== 1'b0) begin
                $display("FAIL release_out_early edge%0d: got %b want 0", i, out);
                bad++;
            end
        end
        total++;
        if (pending !== 8'hFF) begin
            $display("FAIL release_pending: got %h want ff", pending);
            bad++;
        end
        step();
        total++;
        if (out !== 1'b1) begin
            $display("FAIL release_out_edge4: got %b want 1", out);
            bad++;
        end
        settle();
    endtask

    // Level channel 0: check latency, pulse width and stretch length.
    task automatic test_level();
        int pend_cnt;
        int out_cnt;
        int first_out;
        int first_pend;
        mask       = 8'h01;
        in_req     = 8'h01;
        pend_cnt   = 0;
        out_cnt    = 0;
        first_out  = 0;
        first_pend = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) in_req = 8'h00;
            if (pending[0] === 1'b1) begin
                pend_cnt++;
                if (first_pend == 0) first_pend = i;
            end
            if (out === 1'b1) begin
                out_cnt++;
                if (first_out == 0) first_out = i;
            end
        end
        total++;
        if (first_pend != 3) begin
            $display("FAIL level_pend_latency: got %0d want 3", first_pend);
            bad++;
        end
        total++;
        if (first_out != 4) begin
            $display("FAIL level_out_latency: got %0d want 4", first_out);
            bad++;
        end
        total++;
        if (pend_cnt != 1) begin
            $display("FAIL level_short_pend_width: got %0d want 1", pend_cnt);
            bad++;
        end
        total++;
        if (out_cnt != 4) begin
            $display("FAIL level_short_out_width: got %0d want 4", out_cnt);
            bad++;
        end
        // A 10-cycle pulse is longer than the stretch, so out is high for exactly 10 cycles.
        in_req   = 8'h01;
        pend_cnt = 0;
        out_cnt  = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 10) in_req = 8'h00;
            if (pending[0] === 1'b1) pend_cnt++;
            if (out === 1'b1) out_cnt++;
        end
        total++;
        if (pend_cnt != 10) begin
            $display("FAIL level_long_pend_width: got %0d want 10", pend_cnt);
            bad++;
        end
        total++;
        if (out_cnt != 10) begin
            $display("FAIL level_long_out_width: got %0d want 10", out_cnt);
            bad++;
        end
        settle();
    endtask

    // Edge channel 3 stays pending after its input falls and is cleared by the
    // strobe. Level channel 1 ignores the same clear.
    task automatic test_edge_clear();
        mask   = 8'h08;
        in_req = 8'h0A;
        repeat (3) step();
        in_req = 8'h02;
        repeat (5) step();
        total++;
        if (pending !== 8'h0A) begin
            $display("FAIL edge_sticky_pending: got %h want 0a", pending);
            bad++;
        end
        total++;
        if (out !== 1'b1) begin
            $display("FAIL edge_sticky_out: got %b want 1", out);
            bad++;
        end
        clr_stb  = 1'b1;
        clr_bits = 8'h0A;
        step();
        clr_stb  = 1'b0;
        clr_bits = 8'h00;
        total++;
        if (pending !== 8'h02) begin
            $display("FAIL edge_clear_pending: got %h want 02", pending);
            bad++;
        end
        total++;
        if (out !== 1'b1) begin
            $display("FAIL edge_clear_out_hold: got %b want 1", out);
            bad++;
        end
        step();
        total++;
        if (out !== 1'b0) begin
            $display("FAIL edge_clear_out_fall: got %b want 0", out);
            bad++;
        end
        settle();
    endtask

    // A clear that lands in the same cycle as a rising edge on channel 3 leaves the bit set.
    task automatic test_set_vs_clear();
        in_req = 8'h08;
        step();
        step();
        clr_stb  = 1'b1;
        clr_bits = 8'h08;
        step();
        clr_stb  = 1'b0;
        clr_bits = 8'h00;
        total++;
        if (pending !== 8'h08) begin
            $display("FAIL set_vs_clear_pending: got %h want 08", pending);
            bad++;
        end
        step();
        total++;
        if (pending !== 8'h08) begin
            $display("FAIL set_vs_clear_hold: got %h want 08", pending);
            bad++;
        end
        settle();
    endtask

    // A masked edge on channel 5 still latches. Unmasking raises out one cycle
    // later, and re-masking still lets the stretch run out.
    task automatic test_mask();
        int out_seen;
        mask     = 8'h00;
        in_req   = 8'h20;
        out_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 3) in_req = 8'h00;
            if (out === 1'b1) out_seen++;
        end
        total++;
        if (pending !== 8'h20) begin
            $display("FAIL mask_pending: got %h want 20", pending);
            bad++;
        end
        total++;
        if (out_seen != 0) begin
            $display("FAIL mask_out_blocked: got %0d high cycles want 0", out_seen);
            bad++;
        end
        mask = 8'h20;
        step();
        total++;
        if (out !== 1'b1) begin
            $display("FAIL mask_unmask_out: got %b want 1", out);
            bad++;
        end
        mask = 8'h00;
        repeat (3) step();
        total++;
        if (out !== 1'b1) begin
            $display("FAIL mask_stretch_hold: got %b want 1", out);
            bad++;
        end
        step();
        total++;
        if (out !== 1'b0) begin
            $display("FAIL mask_stretch_end: got %b want 0", out);
            bad++;
        end
        settle();
    endtask

    // Reset applied in the middle of a stretch clears everything at once.
    task automatic test_reset_mid();
        int waited;
        mask   = 8'h01;
        in_req = 8'h09;
        waited = 0;
        while (out !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        total++;
        if (out !== 1'b1) begin
            $display("FAIL reset_mid_timeout: got %b want 1 within 10 cycles", out);
            bad++;
        end
        step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out !== 1'b0) begin
            $display("FAIL reset_mid_out: got %b want 0", out);
            bad++;
        end
        total++;
        if (pending !== 8'h00) begin
            $display("FAIL reset_mid_pending: got %h want 00", pending);
            bad++;
        end
        in_req = 8'h00;
        repeat (2) step();
        reset = 1'b0;
        repeat (6) step();
        total++;
        if (out !== 1'b0 || pending !== 8'h00) begin
            $display("FAIL reset_mid_quiet: got out=%b pending=%h want out=0 pending=00", out, pending);
            bad++;
        end
    endtask

    // Run the scenarios in order, then print the final report.
    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        in_req   = 8'h00;
        mask     = 8'h00;
        clr_stb  = 1'b0;
        clr_bits = 8'h00;
        test_reset();
        test_level();
        test_edge_clear();
        test_set_vs_clear();
        test_mask();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
